// File: rtl/somador_pkg.sv
// somador_pkg
// Shared types and elaboration helpers for the serial adder/subtractor.
//   op_e     : operation select (OP_ADD, OP_SUB)
//   state_e  : control FSM states (S_IDLE, S_CALC, S_DONE)
//   chunk_fits(): true when CHUNK is in 1..WIDTH and divides WIDTH evenly
//   idx_bits()  : width of the slice index register for a given slice count
package somador_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic bit chunk_fits(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soma_chunk.sv
// soma_chunk
// Combinational CHUNK-bit ripple slice built from 1-bit full-adder equations.
// Ports:
//   a, b      : slice operands (CHUNK bits)
//   cin       : carry into bit 0
//   s         : slice sum (CHUNK bits)
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (used for signed overflow detection)
module soma_chunk
    import somador_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    // Ripple chain: c[i] is the carry into bit i.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/somador_serial_param.sv
// somador_serial_param
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice is reused over
// WIDTH/CHUNK cycles with a registered carry between slices.
// Optional feature macro: SOMADOR_OVF_EN (signed overflow flag; when
// undefined, ovf is tied to 0 and its flop is not built).
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operation handshake (op, a, b sampled on accept)
//   op                   : 0 = add, 1 = subtract (a - b)
//   a, b                 : WIDTH-bit operands
//   out_valid / out_ready: result handshake
//   s                    : result modulo 2^WIDTH
//   cout                 : carry out of MSB (subtract: 1 = no borrow)
//   zero                 : s == 0, only while out_valid
//   ovf                  : signed two's-complement overflow
module somador_serial_param
    import somador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = idx_bits(N);
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_chunk
        $error("somador_serial_param: CHUNK must be in 1..WIDTH and divide WIDTH");
    end

    state_e           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] s_reg;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic             sub;
    logic             last_slice;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_s;
    logic             slice_cout;
    logic             slice_cmsb;

    assign sub        = (op_e'(op) == OP_SUB);
    assign last_slice = (idx == LAST);
    assign slice_a    = opa[int'(idx)*CHUNK +: CHUNK];
    assign slice_b    = opb[int'(idx)*CHUNK +: CHUNK];

    soma_chunk #(
        .CHUNK    (CHUNK)
    ) u_chunk (
        .a        (slice_a),
        .b        (slice_b),
        .cin      (carry),
        .s        (slice_s),
        .cout     (slice_cout),
        .c_msb_in (slice_cmsb)
    );

    // Control FSM, operand capture and result/carry registers.
    // Subtraction is a + ~b + 1: b is inverted on capture and the +1 enters
    // as the initial carry. in_ready/out_valid are registered alongside the
    // state so they come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            opa       <= '0;
            opb       <= '0;
            s_reg     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        opa      <= a;
                        opb      <= b ^ {WIDTH{sub}};
                        carry    <= sub;
                        idx      <= '0;
                        state    <= S_CALC;
                        in_ready <= 1'b0;
                    end
                end
                S_CALC: begin
                    s_reg[int'(idx)*CHUNK +: CHUNK] <= slice_s;
                    carry <= slice_cout;
                    if (last_slice) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef SOMADOR_OVF_EN
    logic ovf_reg;

    // Signed overflow: carry into the MSB differs from carry out of it.
    // Captured together with the final slice so it is stable in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state == S_CALC && last_slice) begin
            ovf_reg <= slice_cmsb ^ slice_cout;
        end
    end

    assign ovf = ovf_reg;
`else
    logic unused_cmsb;
    assign unused_cmsb = slice_cmsb;
    assign ovf         = 1'b0;
`endif

    assign s    = s_reg;
    assign cout = carry;
    assign zero = out_valid && (s_reg == '0);

endmodule

// File: tb/tb_somador_serial_param.sv
// tb_somador_serial_param
// Directed bench for somador_serial_param (WIDTH = 8, CHUNK = 2).
// A reference model derives s/cout/zero/ovf from plain signed/unsigned
// arithmetic at each accepted operation; a compare process checks the DUT
// against it on every cycle out_valid is high. Each directed vector also
// carries hand-computed literal results. Honours SOMADOR_OVF_EN.
module tb_somador_serial_param;

    localparam int WIDTH = 8;
    localparam int CHUNK = 2;
    localparam int N     = WIDTH / CHUNK;

`ifdef SOMADOR_OVF_EN
    localparam int OVF_ON = 1;
`else
    localparam int OVF_ON = 0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             zero;
    logic             ovf;

    int checks;
    int errors;

    int exp_s;
    int exp_c;
    int exp_z;
    int exp_v;
    bit pending;

    somador_serial_param #(
        .WIDTH     (WIDTH),
        .CHUNK     (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared comparison: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Reference arithmetic: unsigned result/carry and signed range overflow.
    function automatic void model(input bit sub, input int ua, input int ub,
                                  output int rs, output int rc, output int rz, output int rv);
        int sa;
        int sb;
        int r;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        if (sub) begin
            rs = (ua - ub) & 255;
            rc = (ua >= ub) ? 1 : 0;
            r  = sa - sb;
        end else begin
            rs = (ua + ub) & 255;
            rc = ((ua + ub) > 255) ? 1 : 0;
            r  = sa + sb;
        end
        rz = (rs == 0) ? 1 : 0;
        rv = (OVF_ON != 0 && (r > 127 || r < -128)) ? 1 : 0;
    endfunction

    // Model update: record expectations on every accepted operation,
    // retire them when the result handshake completes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else begin
            int rs, rc, rz, rv;
            if (out_valid && out_ready) pending <= 1'b0;
            if (in_valid && in_ready) begin
                model(op, int'(a), int'(b), rs, rc, rz, rv);
                exp_s   <= rs;
                exp_c   <= rc;
                exp_z   <= rz;
                exp_v   <= rv;
                pending <= 1'b1;
            end
        end
    end

    // Compare process: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!pending) begin
                checkOutput("spurious_out_valid", 1, 0);
            end else begin
                checkOutput("cmp_s", int'(s), exp_s);
                checkOutput("cmp_cout", int'(cout), exp_c);
                checkOutput("cmp_zero", int'(zero), exp_z);
                checkOutput("cmp_ovf", int'(ovf), exp_v);
                checkOutput("cmp_in_ready_low", int'(in_ready), 0);
            end
        end
    end

    // Present one operation and wait for the accepting edge.
    task automatic applyStimulus(input bit sub, input int ua, input int ub, input bit scramble);
        @(negedge clk);
        checkOutput("in_ready_before_accept", int'(in_ready), 1);
        op       = sub;
        a        = WIDTH'(ua);
        b        = WIDTH'(ub);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!scramble) in_valid = 1'b0;
    endtask

    task automatic runOp(input string name, input bit sub, input int ua, input int ub,
                         input int es, input int ec, input int ez, input int ev,
                         input bit scramble, input bit hold);
        int lat;
        lat = 0;
        applyStimulus(sub, ua, ub, scramble);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (scramble) begin
                a        = WIDTH'($urandom);
                b        = WIDTH'($urandom);
                op       = ~op;
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        checkOutput({name, "_latency"}, lat, N);
        checkOutput({name, "_s"}, int'(s), es);
        checkOutput({name, "_cout"}, int'(cout), ec);
        checkOutput({name, "_zero"}, int'(zero), ez);
        checkOutput({name, "_ovf"}, int'(ovf), ev);
        if (hold) begin
            repeat (10) begin
                @(posedge clk);
                #1;
                checkOutput({name, "_hold_valid"}, int'(out_valid), 1);
                checkOutput({name, "_hold_in_ready"}, int'(in_ready), 0);
            end
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput({name, "_back_idle_valid"}, int'(out_valid), 0);
        checkOutput({name, "_back_idle_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        #12;
        checkOutput("reset_s", int'(s), 0);
        checkOutput("reset_cout", int'(cout), 0);
        checkOutput("reset_zero", int'(zero), 0);
        checkOutput("reset_ovf", int'(ovf), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", int'(in_ready), 1);

        runOp("add_200_100", 1'b0, 200, 100, 44, 1, 0, 0, 1'b0, 1'b0);
        runOp("sub_5_5", 1'b1, 5, 5, 0, 1, 1, 0, 1'b0, 1'b0);
        runOp("sub_3_5", 1'b1, 3, 5, 254, 0, 0, 0, 1'b0, 1'b0);
        runOp("add_100_100", 1'b0, 100, 100, 200, 0, 0, OVF_ON, 1'b0, 1'b0);
        runOp("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1, 0, OVF_ON, 1'b0, 1'b0);
        runOp("add_ff_01", 1'b0, 8'hFF, 8'h01, 0, 1, 1, 0, 1'b0, 1'b0);

        out_ready = 1'b0;
        runOp("hold_sub_9_4", 1'b1, 9, 4, 5, 1, 0, 0, 1'b0, 1'b1);

        runOp("scramble_add_17_34", 1'b0, 17, 34, 51, 0, 0, 0, 1'b1, 1'b0);
        repeat (N + 4) begin
            @(posedge clk);
            #1;
            checkOutput("no_second_op", int'(out_valid), 0);
        end

        applyStimulus(1'b0, 10, 20, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midcalc_reset_s", int'(s), 0);
        checkOutput("midcalc_reset_cout", int'(cout), 0);
        checkOutput("midcalc_reset_zero", int'(zero), 0);
        checkOutput("midcalc_reset_ovf", int'(ovf), 0);
        checkOutput("midcalc_reset_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midcalc_reset_in_ready", int'(in_ready), 1);
        runOp("after_reset_1_1", 1'b0, 1, 1, 2, 0, 0, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
